// File: rtl/dea_frame_tx_pkg.sv
// Shared constants and state encodings for the DEA host-side frame transmitter.
// Imported by the top, the byte handshake sub-module and benches.
package dea_frame_tx_pkg;

    localparam int unsigned MaxDataDefault = 100;
    localparam int unsigned MaxKeyDefault  = 3;
    localparam int unsigned AddrWDefault   = 7;

    localparam logic WrSelData = 1'b0;
    localparam logic WrSelKey  = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StHdrD,
        StData,
        StHdrK,
        StKey,
        StFin
    } main_state_e;

    typedef enum logic [1:0] {
        PhIssue,
        PhAck,
        PhDrain
    } hs_phase_e;

    // A field length is legal when it is non-zero and fits its buffer.
    function automatic logic len_ok(input logic [7:0] len, input int unsigned max_len);
        return (len != 8'd0) && (32'(len) <= max_len);
    endfunction

endpackage

// File: rtl/dea_frame_tx_if.sv
// UART_Sender-style byte interface: byte + one-cycle send strobe out, busy flag back.
interface dea_frame_tx_if;

    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_busy;

    modport master (
        output tx_data,
        output tx_send,
        input  tx_busy
    );

    modport slave (
        input  tx_data,
        input  tx_send,
        output tx_busy
    );

endinterface

// File: rtl/dea_frame_tx_uart_byte_handshake.sv
// Moves one byte through the send/busy handshake (ISSUE -> ACK -> DRAIN).
// Kept standalone so the result-return path can reuse it.
module dea_frame_tx_uart_byte_handshake
    import dea_frame_tx_pkg::*;
(
    input  logic       Clk_100M,
    input  logic       Reset,
    input  logic       req_i,
    input  logic [7:0] byte_i,
    input  logic       tx_busy_i,
    output logic [7:0] tx_data_o,
    output logic       tx_send_o,
    output logic       byte_done_o
);

    hs_phase_e  phase_q, phase_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_send_q, tx_send_d;

    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            phase_q   <= PhIssue;
            tx_data_q <= 8'd0;
            tx_send_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            tx_data_q <= tx_data_d;
            tx_send_q <= tx_send_d;
        end
    end

    always_comb begin
        phase_d     = phase_q;
        tx_data_d   = tx_data_q;
        tx_send_d   = 1'b0;
        byte_done_o = 1'b0;
        case (phase_q)
            PhIssue: begin
                // A sender still busy from elsewhere holds us here without a strobe.
                if (req_i && !tx_busy_i) begin
                    tx_data_d = byte_i;
                    tx_send_d = 1'b1;
                    phase_d   = PhAck;
                end
            end
            PhAck: begin
                if (tx_busy_i) begin
                    phase_d = PhDrain;
                end
            end
            PhDrain: begin
                if (!tx_busy_i) begin
                    byte_done_o = 1'b1;
                    phase_d     = PhIssue;
                end
            end
            default: phase_d = PhIssue;
        endcase
    end

    assign tx_data_o = tx_data_q;
    assign tx_send_o = tx_send_q;

endmodule

// File: rtl/dea_frame_tx.sv
// Host-side framer: serialises [data_len][data..][key_len][key..] from local buffers
// through the UART byte handshake on a start pulse.
module dea_frame_tx
    import dea_frame_tx_pkg::*;
#(
    parameter int unsigned MAX_DATA = MaxDataDefault,
    parameter int unsigned MAX_KEY  = MaxKeyDefault,
    parameter int unsigned ADDR_W   = AddrWDefault
) (
    input  logic              Clk_100M,
    input  logic              Reset,
    input  logic              wr_en_i,
    input  logic              wr_sel_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [7:0]        wr_byte_i,
    input  logic [7:0]        data_len_i,
    input  logic [7:0]        key_len_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    dea_frame_tx_if.master    uart_tx
);

    localparam int unsigned KeyAw = (MAX_KEY > 1) ? $clog2(MAX_KEY) : 1;

    logic [7:0] data_mem [MAX_DATA];
    logic [7:0] key_mem  [MAX_KEY];

    main_state_e state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  data_len_q, data_len_d;
    logic [7:0]  key_len_q, key_len_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        hs_req;
    logic [7:0]  hs_byte;
    logic        hs_byte_done;

    // Buffers are deliberately not reset; out-of-range and in-frame writes are dropped.
    always_ff @(posedge Clk_100M) begin
        if (wr_en_i && !busy_q) begin
            if (wr_sel_i == WrSelData && 32'(wr_addr_i) < MAX_DATA) begin
                data_mem[wr_addr_i] <= wr_byte_i;
            end
            if (wr_sel_i == WrSelKey && 32'(wr_addr_i) < MAX_KEY) begin
                key_mem[wr_addr_i[KeyAw-1:0]] <= wr_byte_i;
            end
        end
    end

    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            state_q    <= StIdle;
            idx_q      <= 8'd0;
            data_len_q <= 8'd0;
            key_len_q  <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            data_len_q <= data_len_d;
            key_len_q  <= key_len_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        data_len_d = data_len_q;
        key_len_d  = key_len_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        hs_req     = 1'b0;
        hs_byte    = 8'd0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (len_ok(data_len_i, MAX_DATA) && len_ok(key_len_i, MAX_KEY)) begin
                        data_len_d = data_len_i;
                        key_len_d  = key_len_i;
                        busy_d     = 1'b1;
                        state_d    = StHdrD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StHdrD: begin
                hs_req  = 1'b1;
                hs_byte = data_len_q;
                if (hs_byte_done) begin
                    idx_d   = 8'd0;
                    state_d = StData;
                end
            end
            StData: begin
                hs_req  = 1'b1;
                hs_byte = data_mem[idx_q[ADDR_W-1:0]];
                if (hs_byte_done) begin
                    if (idx_q == data_len_q - 8'd1) begin
                        state_d = StHdrK;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            StHdrK: begin
                hs_req  = 1'b1;
                hs_byte = key_len_q;
                if (hs_byte_done) begin
                    idx_d   = 8'd0;
                    state_d = StKey;
                end
            end
            StKey: begin
                hs_req  = 1'b1;
                hs_byte = key_mem[idx_q[KeyAw-1:0]];
                if (hs_byte_done) begin
                    if (idx_q == key_len_q - 8'd1) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StFin;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    dea_frame_tx_uart_byte_handshake u_byte_hs (
        .Clk_100M    (Clk_100M),
        .Reset       (Reset),
        .req_i       (hs_req),
        .byte_i      (hs_byte),
        .tx_busy_i   (uart_tx.tx_busy),
        .tx_data_o   (uart_tx.tx_data),
        .tx_send_o   (uart_tx.tx_send),
        .byte_done_o (hs_byte_done)
    );

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_dea_frame_tx.sv
// Randomised bench for dea_frame_tx: a UART sender model captures the byte stream and
// compares it with frames rebuilt from the bench's own copy of the buffers.
module tb_dea_frame_tx;

    logic       Clk_100M = 1'b0;
    logic       Reset    = 1'b1;
    logic       wr_en    = 1'b0;
    logic       wr_sel   = 1'b0;
    logic [6:0] wr_addr  = '0;
    logic [7:0] wr_byte  = '0;
    logic [7:0] data_len = '0;
    logic [7:0] key_len  = '0;
    logic       start    = 1'b0;
    logic       busy, done, err;

    always #5 Clk_100M = ~Clk_100M;

    dea_frame_tx_if u_if ();

    dea_frame_tx dut (
        .Clk_100M   (Clk_100M),
        .Reset      (Reset),
        .wr_en_i    (wr_en),
        .wr_sel_i   (wr_sel),
        .wr_addr_i  (wr_addr),
        .wr_byte_i  (wr_byte),
        .data_len_i (data_len),
        .key_len_i  (key_len),
        .start_i    (start),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .uart_tx    (u_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ref_data [100];
    logic [7:0] ref_key  [3];

    logic [7:0] rx_q [$];
    int   send_cnt = 0, done_cnt = 0, err_cnt = 0, busy_viol = 0, send_while_busy = 0;
    int   cyc = 0, last_fall_cyc = 0, done_cyc = 0, sender_cnt = 0, busy_cycles = 10;
    logic force_busy = 1'b0;
    logic in_frame   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // UART sender model plus frame monitor, all sampled on the falling edge.
    initial begin
        u_if.tx_busy = 1'b0;
        forever begin
            logic prev_busy;
            @(negedge Clk_100M);
            cyc++;
            if (sender_cnt > 0) sender_cnt--;
            if (u_if.tx_send === 1'b1) begin
                if (u_if.tx_busy) send_while_busy++;
                rx_q.push_back(u_if.tx_data);
                send_cnt++;
                sender_cnt = busy_cycles;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                in_frame = 1'b0;
            end
            if (err === 1'b1) err_cnt++;
            if (in_frame && busy !== 1'b1) busy_viol++;
            prev_busy    = u_if.tx_busy;
            u_if.tx_busy = force_busy || (sender_cnt != 0);
            if (prev_busy && !u_if.tx_busy) last_fall_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge Clk_100M);
        #1;
    endtask

    task automatic wr(input logic sel, input logic [6:0] addr, input logic [7:0] b);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = addr;
        wr_byte = b;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic fill(input int dl, input int kl);
        for (int i = 0; i < dl; i++) begin
            ref_data[i] = 8'($urandom);
            wr(1'b0, 7'(i), ref_data[i]);
        end
        for (int i = 0; i < kl; i++) begin
            ref_key[i] = 8'($urandom);
            wr(1'b1, 7'(i), ref_key[i]);
        end
    endtask

    task automatic pulse_start(input int dl, input int kl);
        data_len = 8'(dl);
        key_len  = 8'(kl);
        start    = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_sends(input int target, input int budget);
        int n = 0;
        while (send_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check_eq("send_wait", (send_cnt >= target), 1);
    endtask

    // Waits for the done pulse of the current frame, then checks the captured stream.
    task automatic finish_frame(input string tag, input int dl, input int kl, input int d0);
        logic [7:0] exp_q [$];
        int n = 0;
        int budget = (dl + kl + 2) * (busy_cycles + 8) + 60;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        tick();
        check_eq({tag, "_done"}, done_cnt, d0 + 1);
        exp_q.push_back(8'(dl));
        for (int i = 0; i < dl; i++) exp_q.push_back(ref_data[i]);
        exp_q.push_back(8'(kl));
        for (int i = 0; i < kl; i++) exp_q.push_back(ref_key[i]);
        check_eq({tag, "_len"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check_eq($sformatf("%s_b%0d", tag, i), rx_q[i], exp_q[i]);
        end
    endtask

    task automatic run_frame(input string tag, input int dl, input int kl);
        int d0 = done_cnt;
        rx_q.delete();
        pulse_start(dl, kl);
        in_frame = 1'b1;
        finish_frame(tag, dl, kl, d0);
    endtask

    initial begin
        int d0, e0, s0;
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        check_eq("rst_tx_data", u_if.tx_data, 0);
        check_eq("rst_tx_send", u_if.tx_send, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);

        // "ABC" / {10,20}; out-of-range writes must not alias onto valid entries.
        ref_data[0] = 8'h41; ref_data[1] = 8'h42; ref_data[2] = 8'h43;
        ref_key[0]  = 8'h10; ref_key[1]  = 8'h20;
        wr(1'b0, 7'd0, 8'h41); wr(1'b0, 7'd1, 8'h42); wr(1'b0, 7'd2, 8'h43);
        wr(1'b1, 7'd0, 8'h10); wr(1'b1, 7'd1, 8'h20);
        wr(1'b1, 7'd4, 8'hEE); wr(1'b1, 7'd5, 8'hEE); wr(1'b0, 7'd100, 8'hEE);
        busy_cycles = 10;
        run_frame("abc", 3, 2);
        check_eq("abc_done_lat", done_cyc - last_fall_cyc, 1);

        // Illegal lengths: err pulse each, nothing sent, busy stays low.
        for (int t = 0; t < 4; t++) begin
            int dl = (t == 0) ? 0 : (t == 1) ? 101 : 5;
            int kl = (t == 2) ? 4 : (t == 3) ? 0 : 1;
            e0 = err_cnt;
            s0 = send_cnt;
            pulse_start(dl, kl);
            repeat (3) tick();
            check_eq($sformatf("bad%0d_err", t), err_cnt, e0 + 1);
            check_eq($sformatf("bad%0d_nosend", t), send_cnt, s0);
            check_eq($sformatf("bad%0d_busy", t), busy, 0);
        end

        // Sender busy before the first byte: no strobe until it drops.
        fill(2, 1);
        force_busy = 1'b1;
        tick();
        d0 = done_cnt;
        s0 = send_cnt;
        rx_q.delete();
        pulse_start(2, 1);
        in_frame = 1'b1;
        repeat (50) tick();
        check_eq("hold_nosend", send_cnt, s0);
        force_busy = 1'b0;
        repeat (4) tick();
        check_eq("hold_one_send", send_cnt, s0 + 1);
        check_eq("hold_first", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hDEAD_BEEF, 2);
        finish_frame("hold", 2, 1, d0);

        // start and a data[0] write while in DATA are both ignored.
        fill(20, 2);
        busy_cycles = 6;
        d0 = done_cnt;
        rx_q.delete();
        pulse_start(20, 2);
        in_frame = 1'b1;
        wait_sends(send_cnt + 4, 200);
        e0 = err_cnt;
        data_len = 8'd5;
        key_len  = 8'd1;
        start    = 1'b1;
        wr(1'b0, 7'd0, 8'hFF);
        start = 1'b0;
        finish_frame("midfrm", 20, 2, d0);
        check_eq("midfrm_noerr", err_cnt, e0);
        run_frame("after", 3, 2);

        // Reset while the second byte is draining.
        busy_cycles = 10;
        fill(10, 1);
        d0 = done_cnt;
        s0 = send_cnt;
        rx_q.delete();
        pulse_start(10, 1);
        in_frame = 1'b1;
        wait_sends(s0 + 2, 100);
        repeat (4) tick();
        Reset = 1'b1;
        tick();
        check_eq("rstmid_send", u_if.tx_send, 0);
        check_eq("rstmid_busy", busy, 0);
        check_eq("rstmid_done", done, 0);
        Reset    = 1'b0;
        in_frame = 1'b0;
        for (int n = 0; n < 40 && u_if.tx_busy; n++) tick();
        check_eq("rstmid_nodone", done_cnt, d0);
        run_frame("post_rst", 1, 1);

        // Largest frame.
        busy_cycles = 2;
        fill(100, 3);
        run_frame("max", 100, 3);
        check_eq("max_pos101", (rx_q.size() > 101) ? 32'(rx_q[101]) : 32'hDEAD_BEEF, 3);

        for (int r = 0; r < 4; r++) begin
            int dl = $urandom_range(1, 40);
            int kl = $urandom_range(1, 3);
            busy_cycles = $urandom_range(1, 12);
            fill(dl, kl);
            run_frame($sformatf("rnd%0d", r), dl, kl);
        end

        check_eq("busy_during_frame", busy_viol, 0);
        check_eq("send_while_busy", send_while_busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
